// File: rtl/mm2x2_seq_ctrl_if.sv
// mm2x2_seq_ctrl_if: byte-stream operand input and result output of the 2x2 matmul sequencer
interface mm2x2_seq_ctrl_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/mm2x2_seq_ctrl.sv
// mm2x2_seq_ctrl: loads 8 operand bytes into the 2x2 matmul datapath, starts it, streams results out.
// Define MM_TIMEOUT_EN to bound WAIT to TIMEOUT cycles, after which a sticky ERR state is entered.
module mm2x2_seq_ctrl #(
  parameter int RES_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  mm2x2_seq_ctrl_if.slave bus,
  output logic dp_load,
  output logic [2:0] dp_load_idx,
  output logic [7:0] dp_load_data,
  output logic dp_start,
  input  logic dp_done,
  input  logic [4*RES_W-1:0] dp_result,
  output logic busy,
  output logic err,
  output logic [7:0] uio_oe
);
  localparam int NB = RES_W / 2;
  localparam int OW = $clog2(NB);
`ifdef MM_TIMEOUT_EN
  localparam int TW = TIMEOUT > 255 ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, ERR} state_t;
  logic [TW-1:0] tmr, tmr_d;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;
`endif
  state_t state, state_d;
  logic [2:0] in_cnt, in_cnt_d;
  logic [OW-1:0] out_cnt, out_cnt_d;
  logic [4*RES_W-1:0] res, res_d;
  logic run, loading, in_fire, out_fire, last_out;
  // handshakes are gated by rst_n too so the outputs read as reset values while it is low
  always_comb begin
    run = ena & rst_n;
    loading = state == IDLE || state == LOAD;
    bus.in_ready = run && loading;
    bus.out_valid = run && state == DRAIN;
    bus.out_data = res[{out_cnt, 3'b000} +: 8];
    in_fire = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    last_out = out_cnt == OW'(NB - 1);
    dp_load = in_fire;
    dp_load_idx = in_cnt;
    dp_load_data = in_fire ? bus.in_data : 8'h00;
    dp_start = run && state == START;
    busy = state != IDLE;
    uio_oe = loading ? 8'h00 : 8'h0F;
    state_d = state;
    in_cnt_d = in_cnt;
    out_cnt_d = out_cnt;
    res_d = res;
    if (in_fire) begin
      state_d = in_cnt == 3'd7 ? START : LOAD;
      in_cnt_d = in_cnt == 3'd7 ? in_cnt : in_cnt + 3'd1;
    end
    if (dp_start) state_d = WAIT;
    if (run && state == WAIT && dp_done) begin
      state_d = DRAIN;
      res_d = dp_result;
    end
    if (out_fire) begin
      state_d = last_out ? IDLE : DRAIN;
      out_cnt_d = last_out ? '0 : out_cnt + 1'b1;
      in_cnt_d = last_out ? 3'd0 : in_cnt;
    end
`ifdef MM_TIMEOUT_EN
    err = state == ERR;
    tmr_d = state == WAIT ? tmr + TW'(run) : '0;
    if (run && state == WAIT && !dp_done && tmr == TW'(TIMEOUT - 1)) state_d = ERR;
`else
    err = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      res <= '0;
`ifdef MM_TIMEOUT_EN
      tmr <= '0;
`endif
    end else if (ena) begin
      state <= state_d;
      in_cnt <= in_cnt_d;
      out_cnt <= out_cnt_d;
      res <= res_d;
`ifdef MM_TIMEOUT_EN
      tmr <= tmr_d;
`endif
    end
endmodule

// File: tb/tb_mm2x2_seq_ctrl.sv
// tb_mm2x2_seq_ctrl: scoreboard bench for mm2x2_seq_ctrl with a behavioural matmul datapath
`timescale 1ns/1ps
module tb_mm2x2_seq_ctrl;
  localparam int RES_W = 16;
  localparam int TMO = 10;
  logic clk = 0, rst_n = 1, ena = 0;
  logic dp_load, dp_start, dp_done, busy, err;
  logic [2:0] dp_load_idx;
  logic [7:0] dp_load_data, uio_oe;
  logic [4*RES_W-1:0] dp_result;
  mm2x2_seq_ctrl_if bus();
  mm2x2_seq_ctrl #(.RES_W(RES_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
    .dp_load(dp_load), .dp_load_idx(dp_load_idx), .dp_load_data(dp_load_data),
    .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
    .busy(busy), .err(err), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, out_xfers = 0, last_load_cyc = -10;
  logic [10:0] exp_load[$];
  logic [7:0] exp_out[$];
  logic [7:0] op[8];
  int wait_cyc = 2, rdy_mode = 0;
  bit stray = 0, tmo_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference: C = A*B on the operand bytes, each element truncated to RES_W
  function automatic logic [63:0] mm(input logic [7:0] o[8]);
    int a[8];
    logic [15:0] c[4];
    foreach (o[k]) a[k] = o[k];
    c[0] = 16'(a[0] * a[4] + a[1] * a[6]);
    c[1] = 16'(a[0] * a[5] + a[1] * a[7]);
    c[2] = 16'(a[2] * a[4] + a[3] * a[6]);
    c[3] = 16'(a[2] * a[5] + a[3] * a[7]);
    return {c[3], c[2], c[1], c[0]};
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_dp_load"}, dp_load, 0);
    chk({tag, "_dp_load_idx"}, dp_load_idx, 0);
    chk({tag, "_dp_load_data"}, dp_load_data, 0);
    chk({tag, "_dp_start"}, dp_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_uio_oe"}, uio_oe, 0);
  endtask
  // monitor: pops the scoreboard queues whenever the DUT presents a load or output byte
  initial begin
    logic stall_prev, load_prev, start_prev;
    logic [7:0] prev_data;
    stall_prev = 0; load_prev = 0; start_prev = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0; load_prev = 0; start_prev = 0;
      end else begin
        if (load_prev) chk("busy_after_load", busy, 1);
        if (dp_load) begin
          chk("load_expected", exp_load.size() != 0, 1);
          if (exp_load.size() != 0) chk("load_idx_data", {dp_load_idx, dp_load_data}, exp_load.pop_front());
          if (dp_load_idx == 3'd7) last_load_cyc = cyc;
        end
        if (dp_start) begin
          chk("start_latency", cyc - last_load_cyc, 1);
          chk("start_single", start_prev, 0);
        end
        if (bus.out_valid) begin
          if (stall_prev) chk("out_stable", bus.out_data, prev_data);
          if (bus.out_ready) begin
            chk("out_expected", exp_out.size() != 0, 1);
            if (exp_out.size() != 0) chk("out_data", bus.out_data, exp_out.pop_front());
            out_xfers++;
          end
          stall_prev = !bus.out_ready;
          prev_data = bus.out_data;
        end else stall_prev = 0;
        if (uio_oe == 8'h0F) chk("in_ready_when_busy", bus.in_ready, 0);
        load_prev = dp_load;
        start_prev = dp_start;
      end
    end
  end
  initial begin
    bus.out_ready = 0;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~bus.out_ready : 1'($urandom_range(0, 1));
    end
  end
  // behavioural datapath: captures operand writes, answers dp_start after wait_cyc WAIT cycles
  initial begin
    dp_done = 0;
    dp_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && dp_load) op[dp_load_idx] = dp_load_data;
      if (rst_n && dp_start) begin
        if (stray) begin
          dp_done = 1;
          dp_result = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        dp_done = 0;
        if (tmo_mode) begin
          for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("err_before_timeout", err, 0);
            @(posedge clk); #1;
          end
          @(negedge clk);
          chk("err_at_timeout", err, 1);
          chk("err_out_valid", bus.out_valid, 0);
          chk("err_busy", busy, 1);
          chk("err_uio_oe", uio_oe, 8'h0F);
        end else begin
          for (int k = 0; k < wait_cyc; k++) begin
            @(negedge clk);
            chk("wait_out_valid", bus.out_valid, 0);
            chk("wait_uio_oe", uio_oe, 8'h0F);
            chk("wait_err", err, 0);
            @(posedge clk); #1;
          end
          dp_done = 1;
          dp_result = mm(op);
          @(posedge clk); #1;
          dp_done = 0;
          dp_result = {$urandom, $urandom};
          @(negedge clk);
          chk("done_to_valid", bus.out_valid, 1);
        end
      end
    end
  end
  task automatic send(input logic [7:0] ops[8], input int gap_pct, input int drop_at);
    logic [63:0] r;
    logic acc;
    int t;
    r = mm(ops);
    for (int k = 0; k < 8; k++) begin
      exp_load.push_back({3'(k), ops[k]});
      exp_out.push_back(r[8*k +: 8]);
    end
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1, 100) <= gap_pct) begin
        bus.in_valid = 0;
        @(posedge clk); #1;
      end
      bus.in_data = ops[i];
      bus.in_valid = 1;
      if (i == drop_at) begin
        ena = 0;
        repeat (5) begin
          @(negedge clk);
          chk("ena_low_in_ready", bus.in_ready, 0);
          chk("ena_low_load", dp_load, 0);
          @(posedge clk); #1;
        end
        ena = 1;
      end
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 50);
      chk("in_accept_bound", acc, 1);
    end
    bus.in_valid = 0;
  endtask
  task automatic finish_txn(input bit junk);
    int t = 0;
    if (junk) begin
      bus.in_data = 8'hEE;
      bus.in_valid = 1;
    end
    while (exp_out.size() != 0 && t < 400) begin
      @(negedge clk);
      if (bus.out_valid) bus.in_valid = 0;
      t++;
    end
    bus.in_valid = 0;
    chk("txn_complete", exp_out.size() == 0 && exp_load.size() == 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_uio_oe", uio_oe, 8'h00);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask
  task automatic rnd_ops(output logic [7:0] o[8]);
    foreach (o[k]) o[k] = 8'($urandom_range(0, 255));
  endtask
  initial begin
    logic [7:0] d[8];
    int base, t;
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end
  initial begin
    logic [7:0] d[8];
    int base, t;
    bus.in_data = 8'hAA;
    bus.in_valid = 1;
    ena = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("por");
    @(posedge clk); #1;
    bus.in_valid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    wait_cyc = 2; rdy_mode = 0; stray = 0;
    send(d, 0, -1);
    finish_txn(1);
    rnd_ops(d);
    rdy_mode = 1; stray = 1;
    send(d, 0, -1);
    finish_txn(0);
    rnd_ops(d);
    rdy_mode = 0; stray = 0;
    send(d, 0, 3);
    finish_txn(0);
    rnd_ops(d);
    wait_cyc = 1;
    base = out_xfers;
    send(d, 0, -1);
    t = 0;
    while (out_xfers < base + 4 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_reached_4", out_xfers - base, 4);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk_reset("mid_drain");
    exp_out.delete();
    exp_load.delete();
    @(posedge clk); #1;
    rst_n = 1;
    rnd_ops(d);
    send(d, 0, -1);
    finish_txn(0);
`ifndef MM_TIMEOUT_EN
    rnd_ops(d);
    wait_cyc = 20;
    send(d, 20, -1);
    finish_txn(0);
`endif
    for (int n = 0; n < 20; n++) begin
      rnd_ops(d);
      rdy_mode = 2;
      wait_cyc = $urandom_range(0, 6);
      stray = 1'($urandom_range(0, 1));
      send(d, 30, -1);
      finish_txn(1'($urandom_range(0, 1)));
    end
`ifdef MM_TIMEOUT_EN
    rnd_ops(d);
    rdy_mode = 0; stray = 0; tmo_mode = 1;
    send(d, 0, -1);
    repeat (TMO + 4) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err, 1);
    rst_n = 0;
    #1;
    chk_reset("after_err");
    exp_out.delete();
    exp_load.delete();
    tmo_mode = 0;
    @(posedge clk); #1;
    rst_n = 1;
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
